lcd_panel_capture: RTL and testbench



---
 rtl/lcd_cap_pkg.sv | 24 ++
 rtl/lcd_cap_fifo.sv | 55 +++++
 rtl/lcd_panel_capture.sv | 197 +++++++++++++++++++
 tb/tb_lcd_panel_capture.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_cap_pkg.sv
// lcd_cap_pkg: shared types and default widths for the LCD panel capture block.
//   cap_state_t  - capture FSM states
//   cap_entry_t  - FIFO entry {pixel, x, y} at the default widths
//   CAP_*        - default geometry widths and FIFO depth
package lcd_cap_pkg;

  localparam int CAP_XW    = 11;
  localparam int CAP_YW    = 11;
  localparam int CAP_DEPTH = 8;
  localparam int PIX_W     = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_FP = 2'd1,
    ACTIVE  = 2'd2
  } cap_state_t;

  typedef struct packed {
    logic [PIX_W-1:0]  pix;
    logic [CAP_XW-1:0] x;
    logic [CAP_YW-1:0] y;
  } cap_entry_t;

endpackage

// File: rtl/lcd_cap_fifo.sv
// lcd_cap_fifo: single-clock show-ahead FIFO of capture entries.
//   clk, rst       - clock, synchronous active-high reset
//   flush          - synchronous empty (pointers cleared)
//   push, din      - write request and entry; accepted when not full, or full with a pop
//   pop            - read request; ignored when empty
//   head           - entry at the read pointer (valid when !empty)
//   empty, full    - occupancy flags
module lcd_cap_fifo
  import lcd_cap_pkg::*;
#(
  parameter type entry_t = cap_entry_t,
  parameter int  DEPTH   = CAP_DEPTH
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   push,
  input  entry_t din,
  input  logic   pop,
  output entry_t head,
  output logic   empty,
  output logic   full
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign head = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/lcd_panel_capture.sv
// lcd_panel_capture: panel-side receiver that rebuilds the LCD pixel stream.
//   HCLK, HRESET            - system clock, synchronous active-high reset
//   enable, tft             - capture enable; 24-bit TFT vs STN (8-bit, zero-extended)
//   exp_ppl, exp_lpp        - expected pixels per line / active lines per frame
//   clear_err               - clears sticky line_err, frame_err, overflow
//   LCDDCLK..LCDVD          - raw panel interface, oversampled on HCLK
//   pix_data/x/y, pix_valid - show-ahead FIFO head; popped when pix_valid & pix_ready
//   frame_done, frame_cnt   - checked-frame-end pulse and wrapping frame count
//
// state   | meaning
// IDLE    | disabled; FIFO flushed, x/y held at zero
// WAIT_FP | enabled, ignoring the panel until the first frame pulse
// ACTIVE  | capturing pixels, checking line and frame geometry
module lcd_panel_capture
  import lcd_cap_pkg::*;
#(
  parameter int XW    = CAP_XW,
  parameter int YW    = CAP_YW,
  parameter int DEPTH = CAP_DEPTH
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          enable,
  input  logic          tft,
  input  logic [XW-1:0] exp_ppl,
  input  logic [YW-1:0] exp_lpp,
  input  logic          clear_err,
  input  logic          LCDDCLK,
  input  logic          LCDFP,
  input  logic          LCDLP,
  input  logic          LCDENA_LCDM,
  input  logic [23:0]   LCDVD,
  output logic [23:0]   pix_data,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          frame_done,
  output logic [15:0]   frame_cnt,
  output logic          line_err,
  output logic          frame_err,
  output logic          overflow
);

  typedef struct packed {
    logic [PIX_W-1:0] pix;
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
  } entry_t;

  typedef struct packed {
    logic        dclk;
    logic        fp;
    logic        lp;
    logic        ena;
    logic [23:0] vd;
  } lcd_in_t;

  // Third stage only needs the strobes: data and ENA are consumed from s2.
  typedef struct packed {
    logic dclk;
    logic fp;
    logic lp;
  } lcd_strb_t;

  lcd_in_t     s1, s2;
  lcd_strb_t   s3;
  logic        cap_ev, lp_ev, fp_ev;
  logic [23:0] pix_ev;

  cap_state_t    state, state_nxt;
  logic [XW-1:0] x, x_nxt;
  logic [YW-1:0] y, y_nxt;
  logic          push, flush, pop;
  logic          line_set, frame_set, ovf_set, done_nxt;
  logic          fifo_empty, fifo_full;
  entry_t        push_entry, head;

  // Edges are detected on s2/s3 and registered once more, so the FSM acts
  // three HCLK edges after a strobe is first sampled.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      s1     <= '0;
      s2     <= '0;
      s3     <= '0;
      cap_ev <= 1'b0;
      lp_ev  <= 1'b0;
      fp_ev  <= 1'b0;
      pix_ev <= '0;
    end else begin
      s1     <= {LCDDCLK, LCDFP, LCDLP, LCDENA_LCDM, LCDVD};
      s2     <= s1;
      s3     <= '{dclk: s2.dclk, fp: s2.fp, lp: s2.lp};
      cap_ev <= s2.dclk & ~s3.dclk & s2.ena;
      lp_ev  <= s2.lp & ~s3.lp;
      fp_ev  <= s2.fp & ~s3.fp;
      pix_ev <= tft ? s2.vd : {16'h0, s2.vd[7:0]};
    end
  end

  // Within one cycle: pixel capture, then line end, then frame end.
  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    push      = 1'b0;
    flush     = 1'b0;
    line_set  = 1'b0;
    frame_set = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        flush = 1'b1;
        x_nxt = '0;
        y_nxt = '0;
        if (enable) state_nxt = WAIT_FP;
      end
      WAIT_FP: begin
        x_nxt = '0;
        y_nxt = '0;
        if (!enable)    state_nxt = IDLE;
        else if (fp_ev) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else begin
          if (cap_ev) begin
            push = 1'b1;
            if (x != '1) x_nxt = x + XW'(1);
          end
          // A line pulse with no pixels is a blanking line.
          if (lp_ev && (x_nxt != '0)) begin
            line_set = (x_nxt != exp_ppl);
            if (y != '1) y_nxt = y + YW'(1);
            x_nxt = '0;
          end
          if (fp_ev) begin
            frame_set = (y_nxt != exp_lpp);
            done_nxt  = 1'b1;
            x_nxt     = '0;
            y_nxt     = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pop        = pix_valid & pix_ready;
  assign ovf_set    = push & fifo_full & ~pop;
  assign push_entry = '{pix: pix_ev, x: x, y: y};

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      x          <= x_nxt;
      y          <= y_nxt;
      frame_done <= done_nxt;
      if (done_nxt) frame_cnt <= frame_cnt + 16'd1;
      line_err   <= (line_err  & ~clear_err) | line_set;
      frame_err  <= (frame_err & ~clear_err) | frame_set;
      overflow   <= (overflow  & ~clear_err) | ovf_set;
    end
  end

  lcd_cap_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk   (HCLK),
    .rst   (HRESET),
    .flush (flush),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .head  (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Outputs read zero while the FIFO is empty so nothing stale leaks out.
  assign pix_valid = ~fifo_empty;
  assign pix_data  = pix_valid ? head.pix : '0;
  assign pix_x     = pix_valid ? head.x   : '0;
  assign pix_y     = pix_valid ? head.y   : '0;

endmodule

// File: tb/tb_lcd_panel_capture.sv
// tb_lcd_panel_capture: randomized scenario bench for lcd_panel_capture.
// Frames are described as lists of line lengths; the expected pixel stream
// and error flags are computed from those lists.
module tb_lcd_panel_capture;

  localparam int XW    = 11;
  localparam int YW    = 11;
  localparam int DEPTH = 8;

  typedef int lens_t [5];

  logic          HCLK = 1'b0;
  logic          HRESET, enable, tft, clear_err;
  logic [XW-1:0] exp_ppl;
  logic [YW-1:0] exp_lpp;
  logic          LCDDCLK, LCDFP, LCDLP, LCDENA_LCDM;
  logic [23:0]   LCDVD;
  logic [23:0]   pix_data;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          pix_valid, pix_ready, frame_done;
  logic [15:0]   frame_cnt;
  logic          line_err, frame_err, overflow;

  int            n_vec = 0;
  int            n_err = 0;
  int            fd_seen = 0;
  int            exp_frames = 0;
  bit            rand_ready = 1'b0;
  logic [45:0]   exp_q [$];
  logic [45:0]   obs_q [$];

  lcd_panel_capture #(.XW(XW), .YW(YW), .DEPTH(DEPTH)) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .enable      (enable),
    .tft         (tft),
    .exp_ppl     (exp_ppl),
    .exp_lpp     (exp_lpp),
    .clear_err   (clear_err),
    .LCDDCLK     (LCDDCLK),
    .LCDFP       (LCDFP),
    .LCDLP       (LCDLP),
    .LCDENA_LCDM (LCDENA_LCDM),
    .LCDVD       (LCDVD),
    .pix_data    (pix_data),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt),
    .line_err    (line_err),
    .frame_err   (frame_err),
    .overflow    (overflow)
  );

  always #5 HCLK = ~HCLK;

  // Consumer side: record every entry that will pop at the coming edge.
  always @(negedge HCLK) begin
    if (pix_valid && pix_ready && !HRESET) obs_q.push_back({pix_data, pix_x, pix_y});
    if (frame_done) fd_seen++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #1;
      if (rand_ready) pix_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic drive_pix(input logic [23:0] d, input logic ena);
    LCDVD       = d;
    LCDENA_LCDM = ena;
    tick(1);
    LCDDCLK = 1'b1;
    tick(2);
    LCDDCLK = 1'b0;
    tick(1);
  endtask

  task automatic pulse(input logic lp, input logic fp);
    LCDLP = lp;
    LCDFP = fp;
    tick(2);
    LCDLP = 1'b0;
    LCDFP = 1'b0;
    tick(2);
  endtask

  // Drives one frame (already ACTIVE) and closes it with a frame pulse.
  // A zero length is a blanking line. comb_end merges the last line pulse
  // with the frame pulse.
  task automatic run_frame(input lens_t lens, input int nl, input bit comb_end,
                           input bit fixed, output bit le, output bit fe);
    int          rows;
    logic [23:0] d;
    rows = 0;
    le   = 1'b0;
    for (int l = 0; l < nl; l++) begin
      if (lens[l] == 0) begin
        drive_pix(24'($urandom), 1'b0);
        drive_pix(24'($urandom), 1'b0);
      end
      for (int i = 0; i < lens[l]; i++) begin
        d = fixed ? 24'hABCDEF : 24'($urandom);
        drive_pix(d, 1'b1);
        exp_q.push_back({(tft ? d : {16'h0, d[7:0]}), XW'(i), YW'(rows)});
      end
      if (lens[l] != 0) begin
        if (lens[l] != int'(exp_ppl)) le = 1'b1;
        rows++;
      end
      if (l == nl - 1 && comb_end) pulse(1'b1, 1'b1);
      else                         pulse(1'b1, 1'b0);
    end
    if (!comb_end) pulse(1'b0, 1'b1);
    LCDENA_LCDM = 1'b0;
    fe = (rows != int'(exp_lpp));
    exp_frames++;
  endtask

  // Scoreboard: drain the FIFO and compare the popped stream with the model.
  task automatic check_stream(input string name);
    int guard;
    int n;
    rand_ready = 1'b0;
    pix_ready  = 1'b1;
    tick(2);
    guard = 0;
    while ((pix_valid || obs_q.size() < exp_q.size()) && guard < 500) begin
      tick(1);
      guard++;
    end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL %s count: got %0d entries, expected %0d", name, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL %s entry %0d: got data=%h x=%0d y=%0d, expected data=%h x=%0d y=%0d",
                 name, i, obs_q[i][45:22], obs_q[i][21:11], obs_q[i][10:0],
                 exp_q[i][45:22], exp_q[i][21:11], exp_q[i][10:0]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    HRESET = 1'b1; enable = 1'b0; tft = 1'b1; clear_err = 1'b0;
    exp_ppl = XW'(4); exp_lpp = YW'(2);
    LCDDCLK = 1'b0; LCDFP = 1'b0; LCDLP = 1'b0; LCDENA_LCDM = 1'b0; LCDVD = '0;
    pix_ready = 1'b0;
    tick(3);
    HRESET = 1'b0;
    tick(1);
    n_vec++;
    if ({pix_valid, frame_done, line_err, frame_err, overflow} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b, expected 00000",
               {pix_valid, frame_done, line_err, frame_err, overflow});
    end
    n_vec++;
    if ({pix_data, pix_x, pix_y} !== 46'h0) begin
      n_err++;
      $display("FAIL reset_pix: got %h, expected 0", {pix_data, pix_x, pix_y});
    end
    n_vec++;
    if (frame_cnt !== 16'h0) begin
      n_err++;
      $display("FAIL reset_frame_cnt: got %0d, expected 0", frame_cnt);
    end
  endtask

  task automatic test_wait_fp();
    enable = 1'b1;
    tick(2);
    for (int i = 0; i < 4; i++) drive_pix(24'($urandom), 1'b1);
    pulse(1'b1, 1'b0);
    tick(4);
    n_vec++;
    if (pix_valid !== 1'b0 || line_err !== 1'b0) begin
      n_err++;
      $display("FAIL wait_fp_ignore: got valid=%b line_err=%b, expected 0 0", pix_valid, line_err);
    end
    pulse(1'b0, 1'b1);
    tick(2);
    n_vec++;
    if (frame_done !== 1'b0 || fd_seen != 0) begin
      n_err++;
      $display("FAIL wait_fp_first: got frame_done pulses=%0d, expected 0", fd_seen);
    end
  endtask

  task automatic test_basic_frame();
    lens_t lens;
    bit    le, fe;
    lens = '{4, 4, 0, 0, 0};
    pix_ready = 1'b1;
    run_frame(lens, 2, 1'b0, 1'b0, le, fe);
    check_stream("basic_stream");
    n_vec++;
    if (line_err !== le || frame_err !== fe) begin
      n_err++;
      $display("FAIL basic_flags: got le=%b fe=%b, expected le=%b fe=%b", line_err, frame_err, le, fe);
    end
    n_vec++;
    if (frame_cnt !== 16'(exp_frames) || fd_seen != exp_frames) begin
      n_err++;
      $display("FAIL basic_frames: got cnt=%0d pulses=%0d, expected %0d", frame_cnt, fd_seen, exp_frames);
    end
  endtask

  task automatic test_latency();
    pix_ready   = 1'b0;
    LCDVD       = 24'h123456;
    LCDENA_LCDM = 1'b1;
    tick(1);
    LCDDCLK = 1'b1;
    tick(2);
    LCDDCLK = 1'b0;
    tick(1);
    n_vec++;
    if (pix_valid !== 1'b0) begin
      n_err++;
      $display("FAIL latency_early: got valid=%b after edge N+2, expected 0", pix_valid);
    end
    tick(1);
    n_vec++;
    if ({pix_valid, pix_data, pix_x, pix_y} !== {1'b1, 24'h123456, 11'd0, 11'd0}) begin
      n_err++;
      $display("FAIL latency_head: got valid=%b data=%h x=%0d y=%0d, expected 1 123456 0 0",
               pix_valid, pix_data, pix_x, pix_y);
    end
    LCDENA_LCDM = 1'b0;
    enable = 1'b0;
    tick(3);
    n_vec++;
    if (pix_valid !== 1'b0) begin
      n_err++;
      $display("FAIL disable_flush: got valid=%b, expected 0", pix_valid);
    end
    enable = 1'b1;
    tick(2);
    pulse(1'b0, 1'b1);
  endtask

  task automatic test_stn();
    lens_t lens;
    bit    le, fe;
    lens = '{4, 4, 0, 0, 0};
    tft = 1'b0;
    pix_ready = 1'b0;
    run_frame(lens, 2, 1'b0, 1'b1, le, fe);
    n_vec++;
    if (pix_valid !== 1'b1 || pix_data !== 24'h0000EF) begin
      n_err++;
      $display("FAIL stn_data: got valid=%b data=%h, expected 1 0000ef", pix_valid, pix_data);
    end
    check_stream("stn_stream");
    tft = 1'b1;
  endtask

  task automatic test_line_err();
    lens_t lens;
    bit    le, fe;
    lens = '{3, 4, 0, 0, 0};
    rand_ready = 1'b1;
    run_frame(lens, 2, 1'b0, 1'b0, le, fe);
    check_stream("short_line_stream");
    n_vec++;
    if (line_err !== 1'b1 || frame_err !== 1'b0) begin
      n_err++;
      $display("FAIL short_line_flags: got le=%b fe=%b, expected 1 0", line_err, frame_err);
    end
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    tick(1);
    n_vec++;
    if (line_err !== 1'b0) begin
      n_err++;
      $display("FAIL clear_err: got line_err=%b, expected 0", line_err);
    end
  endtask

  task automatic test_overflow();
    logic [23:0] d;
    exp_ppl = XW'(10);
    exp_lpp = YW'(1);
    rand_ready = 1'b0;
    pix_ready  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      d = 24'($urandom);
      drive_pix(d, 1'b1);
      if (i < DEPTH) exp_q.push_back({d, XW'(i), YW'(0)});
    end
    pulse(1'b1, 1'b0);
    n_vec++;
    if (overflow !== 1'b1 || pix_valid !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_set: got ovf=%b valid=%b, expected 1 1", overflow, pix_valid);
    end
    check_stream("overflow_drain");
    pulse(1'b0, 1'b1);
    exp_frames++;
    tick(1);
    n_vec++;
    if ({line_err, frame_err, overflow} !== 3'b001) begin
      n_err++;
      $display("FAIL overflow_sticky: got le/fe/ovf=%b, expected 001", {line_err, frame_err, overflow});
    end
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    tick(1);
    n_vec++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL overflow_clear: got %b, expected 0", overflow);
    end
    exp_ppl = XW'(4);
    exp_lpp = YW'(2);
  endtask

  task automatic test_blanking();
    lens_t lens;
    bit    le, fe;
    rand_ready = 1'b1;
    lens = '{0, 0, 4, 0, 4};
    run_frame(lens, 5, 1'b0, 1'b0, le, fe);
    check_stream("blank_stream");
    n_vec++;
    if (line_err !== le || frame_err !== fe || le || fe) begin
      n_err++;
      $display("FAIL blank_flags: got le=%b fe=%b, expected 0 0", line_err, frame_err);
    end
    lens = '{4, 4, 4, 0, 0};
    run_frame(lens, 3, 1'b0, 1'b0, le, fe);
    check_stream("three_line_stream");
    n_vec++;
    if (frame_err !== 1'b1 || line_err !== 1'b0) begin
      n_err++;
      $display("FAIL three_line_flags: got le=%b fe=%b, expected 0 1", line_err, frame_err);
    end
    n_vec++;
    if (frame_cnt !== 16'(exp_frames)) begin
      n_err++;
      $display("FAIL blank_frame_cnt: got %0d, expected %0d", frame_cnt, exp_frames);
    end
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
  endtask

  task automatic test_random();
    lens_t lens;
    int    nl;
    bit    le, fe, comb;
    for (int f = 0; f < 8; f++) begin
      exp_ppl = XW'($urandom_range(3, 5));
      exp_lpp = YW'($urandom_range(1, 3));
      nl      = $urandom_range(1, 4);
      comb    = $urandom_range(0, 1);
      for (int l = 0; l < 5; l++) lens[l] = $urandom_range(0, 6);
      clear_err = 1'b1;
      tick(1);
      clear_err  = 1'b0;
      rand_ready = 1'b1;
      run_frame(lens, nl, comb, 1'b0, le, fe);
      check_stream("random_stream");
      n_vec++;
      if ({line_err, frame_err, overflow} !== {le, fe, 1'b0}) begin
        n_err++;
        $display("FAIL random_flags f%0d: got le/fe/ovf=%b, expected %b", f,
                 {line_err, frame_err, overflow}, {le, fe, 1'b0});
      end
      n_vec++;
      if (frame_cnt !== 16'(exp_frames) || fd_seen != exp_frames) begin
        n_err++;
        $display("FAIL random_frames f%0d: got cnt=%0d pulses=%0d, expected %0d", f,
                 frame_cnt, fd_seen, exp_frames);
      end
    end
  endtask

  task automatic test_reset_mid();
    lens_t lens;
    bit    le, fe;
    rand_ready = 1'b0;
    pix_ready  = 1'b0;
    exp_ppl    = XW'(4);
    exp_lpp    = YW'(2);
    drive_pix(24'($urandom), 1'b1);
    drive_pix(24'($urandom), 1'b1);
    HRESET = 1'b1;
    tick(1);
    n_vec++;
    if ({pix_valid, frame_done, line_err, frame_err, overflow, frame_cnt, pix_data, pix_x, pix_y} !== '0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: got valid=%b cnt=%0d data=%h, expected all zero",
               pix_valid, frame_cnt, pix_data);
    end
    exp_frames = 0;
    fd_seen    = 0;
    tick(1);
    HRESET = 1'b0;
    tick(2);
    for (int i = 0; i < 3; i++) drive_pix(24'($urandom), 1'b1);
    tick(4);
    n_vec++;
    if (pix_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_wait_fp: got valid=%b, expected 0", pix_valid);
    end
    pulse(1'b0, 1'b1);
    lens = '{4, 4, 0, 0, 0};
    rand_ready = 1'b1;
    run_frame(lens, 2, 1'b1, 1'b0, le, fe);
    check_stream("post_reset_stream");
    n_vec++;
    if ({line_err, frame_err} !== {le, fe} || frame_cnt !== 16'd1 || fd_seen != 1) begin
      n_err++;
      $display("FAIL post_reset_frame: got le=%b fe=%b cnt=%0d pulses=%0d, expected %b %b 1 1",
               line_err, frame_err, frame_cnt, fd_seen, le, fe);
    end
  endtask

  initial begin
    test_reset();
    test_wait_fp();
    test_basic_frame();
    test_latency();
    test_stn();
    test_line_err();
    test_overflow();
    test_blanking();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
